// File: rtl/tdm_demux16_rx.sv
// rtl/tdm_demux16_rx.sv - serial TDM frame receiver rebuilding an N-bit parallel word
module tdm_demux16_rx #(
    parameter int N  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync,
    input  logic          din,
    output logic [N-1:0]  data_out,
    output logic          valid,
    output logic          frame_err,
    output logic [SW-1:0] slot
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT  = SW'(N - 1);
    localparam logic [SW-1:0] FIRST_NEXT = SW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  shadow;
    logic [N-1:0]  shadow_nxt;
    logic [N-1:0]  data_out_nxt;
    logic [SW-1:0] slot_nxt;
    logic          valid_nxt;
    logic          frame_err_nxt;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decode; a sync strobe always restarts at slot 0
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        data_out_nxt  = data_out;
        slot_nxt      = slot;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        shadow_nxt    = '0;
                        shadow_nxt[0] = din;
                        slot_nxt      = FIRST_NEXT;
                        state_nxt     = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        frame_err_nxt = 1'b1;
                        shadow_nxt    = '0;
                        shadow_nxt[0] = din;
                        slot_nxt      = FIRST_NEXT;
                    end else if (slot == LAST_SLOT) begin
                        data_out_nxt        = shadow;
                        data_out_nxt[N-1]   = din;
                        valid_nxt           = 1'b1;
                        slot_nxt            = '0;
                        state_nxt           = IDLE;
                    end else begin
                        shadow_nxt[slot] = din;
                        slot_nxt         = slot + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

    // Registered datapath and output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            data_out  <= '0;
            slot      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            data_out  <= data_out_nxt;
            slot      <= slot_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_demux16_rx.sv
// tb/tb_tdm_demux16_rx.sv - self-checking bench for tdm_demux16_rx
module tb_tdm_demux16_rx;

    localparam int N  = 16;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          sync;
    logic          din;
    logic [N-1:0]  data_out;
    logic          valid;
    logic          frame_err;
    logic [SW-1:0] slot;

    int tests_run;
    int tests_failed;

    // Reference model state: bits gathered since the last accepted sync
    bit            bits_q[$];
    bit            in_frame;
    logic [N-1:0]  exp_data;
    logic          exp_valid;
    logic          exp_err;
    int            exp_slot;

    tdm_demux16_rx #(.N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .din       (din),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .slot      (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        in_frame  = 1'b0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_slot  = 0;
    endtask

    // A frame is N accepted strobes opened by sync; the word is the weighted sum of its bits
    task automatic model_step(input logic e, input logic s, input logic d);
        logic [N-1:0] w;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (e) begin
            if (s) begin
                if (in_frame) exp_err = 1'b1;
                bits_q.delete();
                bits_q.push_back(d);
                in_frame = 1'b1;
            end else if (in_frame) begin
                bits_q.push_back(d);
                if (bits_q.size() == N) begin
                    w = '0;
                    for (int i = 0; i < N; i++) w = w + (N'(bits_q[i]) << i);
                    exp_data  = w;
                    exp_valid = 1'b1;
                    in_frame  = 1'b0;
                    bits_q.delete();
                end
            end
        end
        exp_slot = in_frame ? bits_q.size() : 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},     32'(valid),     32'(exp_valid));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(exp_err));
        chk({tag, ".data_out"},  32'(data_out),  32'(exp_data));
        chk({tag, ".slot"},      32'(slot),      32'(exp_slot));
    endtask

    task automatic step(input string tag, input logic e, input logic s, input logic d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
        model_step(e, s, d);
        check_all(tag);
    endtask

    task automatic send_frame(input string tag, input logic [N-1:0] w, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++)
                    step({tag, ".gap"}, 1'b0, 1'($urandom), 1'($urandom));
            end
            step(tag, 1'b1, (i == 0), w[i]);
        end
    endtask

    initial begin
        logic [N-1:0] w;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        model_reset();

        // Reset state observed before any clock edge
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame A5C3
        send_frame("fa5c3", 16'hA5C3, 1'b0);
        chk("fa5c3.word", 32'(data_out), 32'h0000_A5C3);
        step("fa5c3.after", 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with no dead cycle
        send_frame("b2b0", 16'h0001, 1'b0);
        chk("b2b0.word", 32'(data_out), 32'h0000_0001);
        send_frame("b2b1", 16'hFFFF, 1'b0);
        chk("b2b1.word", 32'(data_out), 32'h0000_FFFF);

        // Frame with random en gaps and sync noise while en is low
        send_frame("gap", 16'h1234, 1'b1);
        chk("gap.word", 32'(data_out), 32'h0000_1234);

        // Abort at slot 9, then a fresh BEEF frame
        w = 16'($urandom);
        for (int i = 0; i < 9; i++) step("abort.part", 1'b1, (i == 0), w[i]);
        chk("abort.slot9", 32'(slot), 32'd9);
        send_frame("beef", 16'hBEEF, 1'b0);
        chk("beef.word", 32'(data_out), 32'h0000_BEEF);

        // Stray strobes in IDLE, then asynchronous reset at slot 7
        for (int i = 0; i < 5; i++) step("stray", 1'b1, 1'b0, 1'($urandom));
        w = 16'($urandom);
        for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, (i == 0), w[i]);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst.stray", 1'b1, 1'b0, 1'b1);
        w = 16'($urandom);
        send_frame("post_rst", w, 1'b0);
        chk("post_rst.word", 32'(data_out), 32'(w));

        // Loopback through a behavioural 16:1 mux driven by a 4-bit select counter
        for (int f = 0; f < 1000; f++) begin
            logic [N-1:0] src;
            src = 16'($urandom);
            for (int sel = 0; sel < N; sel++) step("loop", 1'b1, (sel == 0), src[sel]);
            chk("loop.word", 32'(data_out), 32'(src));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
